// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared processor-side definitions for the instruction-memory
//                loader: default memory geometry and the loader FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Default instruction memory geometry (8-bit entries)
    localparam int c_MEM_DEPTH = 32;
    localparam int c_ADDR_W    = 5;

    // Loader FSM encoding, 5 states in 3 bits
    typedef logic [2:0] state_t;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DATA  = 3'd1;
    localparam logic [2:0] c_ST_CHECK = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_ERROR = 3'd4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Load-stream input, instruction-memory write port and
//                processor control/status signals of the loader.
//                  in_data/in_valid/in_ready : byte stream handshake
//                  abort                     : discard current load
//                  mem_we/mem_addr/mem_data  : instruction memory write port
//                  cpu_reset                 : holds the processor in reset
//                  load_done/load_error      : outcome of the last load
//                master = stream source / system side, slave = loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;

    modport master (
        output in_data, in_valid, abort,
        input  in_ready, mem_we, mem_addr, mem_data,
        input  cpu_reset, load_done, load_error
    );

    modport slave (
        input  in_data, in_valid, abort,
        output in_ready, mem_we, mem_addr, mem_data,
        output cpu_reset, load_done, load_error
    );

endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a framed byte stream (length L, L instruction
//                bytes, XOR checksum) and writes the instruction bytes into
//                instruction memory at addresses 0..L-1. The processor is
//                held in reset (cpu_reset=1) except after a good load.
//  Ports       : clk - clock, rst - synchronous active-high reset,
//                bus - imem_loader_if.slave (stream, memory port, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = c_MEM_DEPTH,
    parameter int ADDR_W    = c_ADDR_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    imem_loader_if.slave  bus
);

    // One extra bit so that L == MEM_DEPTH is representable
    localparam int c_CW = ADDR_W + 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   r_len;
    logic [7:0]        r_csum;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_data;
    logic              r_cpu_reset;
    logic              r_load_done;
    logic              r_load_error;

    logic              w_hs;
    logic              w_len_bad;
    logic              w_last;
    logic [c_CW-1:0]   w_len_in;

    assign bus.in_ready   = ~bus.abort;
    assign w_hs           = bus.in_valid & ~bus.abort;

    // A legal length always fits in c_CW bits, so truncation is harmless
    assign w_len_in  = c_CW'(bus.in_data);
    assign w_len_bad = (bus.in_data == 8'd0) || (32'(bus.in_data) > 32'(MEM_DEPTH));
    assign w_last    = (r_count == (r_len - c_CW'(1)));

    always_comb begin
        w_state_next = r_state;
        if (bus.abort) begin
            w_state_next = c_ST_IDLE;
        end else if (w_hs) begin
            case (r_state)
                c_ST_DATA:  if (w_last) w_state_next = c_ST_CHECK;
                c_ST_CHECK: w_state_next = (bus.in_data == r_csum) ? c_ST_DONE : c_ST_ERROR;
                // IDLE, DONE, ERROR (and any stray encoding): byte is a length
                default:    w_state_next = w_len_bad ? c_ST_ERROR : c_ST_DATA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_count      <= '0;
            r_len        <= '0;
            r_csum       <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mem_we     <= 1'b0;
            // Status follows the state being entered, so a length byte in
            // DONE re-asserts cpu_reset on the same edge that leaves DONE
            r_cpu_reset  <= (w_state_next != c_ST_DONE);
            r_load_done  <= (w_state_next == c_ST_DONE);
            r_load_error <= (w_state_next == c_ST_ERROR);
            if (w_hs) begin
                if (r_state == c_ST_DATA) begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_count[ADDR_W-1:0];
                    r_mem_data <= bus.in_data;
                    r_csum     <= r_csum ^ bus.in_data;
                    r_count    <= r_count + c_CW'(1);
                end else if ((r_state != c_ST_CHECK) && !w_len_bad) begin
                    r_count <= '0;
                    r_csum  <= '0;
                    r_len   <= w_len_in;
                end
            end
        end
    end

    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_data   = r_mem_data;
    assign bus.cpu_reset  = r_cpu_reset;
    assign bus.load_done  = r_load_done;
    assign bus.load_error = r_load_error;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Frames are described
//                as byte lists; the expected writes and final status are
//                derived from the frame format (length, payload, XOR).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   we_count;
    logic [7:0] frame[$];

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(
        .MEM_DEPTH (DEPTH),
        .ADDR_W    (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.mem_we === 1'b1) we_count++;

    // {cpu_reset, load_done, load_error}
    localparam logic [2:0] S_BUSY = 3'b100;
    localparam logic [2:0] S_DONE = 3'b010;
    localparam logic [2:0] S_ERR  = 3'b101;

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Sends the whole frame in 'frame' with min_gap..max_gap idle cycles
    // before each byte, checking every write and the status after each byte.
    task automatic run_frame(input string name, input int min_gap, input int max_gap);
        int          len;
        bit          len_ok;
        int          last;
        logic [7:0]  x;
        logic [2:0]  st;
        logic [2:0]  st_exp;
        int          gap;
        len    = int'(frame[0]);
        len_ok = (len != 0) && (len <= DEPTH);
        last   = len_ok ? len + 1 : 0;
        x      = 8'h00;
        if (len_ok) for (int i = 1; i <= len; i++) x ^= frame[i];
        for (int i = 0; i <= last; i++) begin
            gap = $urandom_range(max_gap, min_gap);
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
                n_vec++;
                if (bus.mem_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s idle-we byte%0d: got %b want 0", name, i, bus.mem_we);
                end
            end
            send_byte(frame[i]);
            n_vec++;
            if (len_ok && i >= 1 && i <= len) begin
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(i - 1) || bus.mem_data !== frame[i]) begin
                    n_err++;
                    $display("FAIL %s write byte%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                             name, i, bus.mem_we, bus.mem_addr, bus.mem_data, i - 1, frame[i]);
                end
            end else if (bus.mem_we !== 1'b0) begin
                n_err++;
                $display("FAIL %s nowrite byte%0d: got we=%b want 0", name, i, bus.mem_we);
            end
            st = {bus.cpu_reset, bus.load_done, bus.load_error};
            if (i < last)                          st_exp = S_BUSY;
            else if (len_ok && frame[last] == x)   st_exp = S_DONE;
            else                                   st_exp = S_ERR;
            n_vec++;
            if (st !== st_exp) begin
                n_err++;
                $display("FAIL %s status byte%0d: got %b want %b", name, i, st, st_exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_data, bus.cpu_reset, bus.load_done, bus.load_error, bus.in_ready}
            !== {1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset: got we=%b addr=%0d data=%h cr=%b dn=%b er=%b rdy=%b want 0 0 00 1 0 0 1",
                     bus.mem_we, bus.mem_addr, bus.mem_data, bus.cpu_reset, bus.load_done, bus.load_error, bus.in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        frame = '{8'h03, 8'h41, 8'h82, 8'hC5, 8'h06};
        run_frame("good", 0, 0);
    endtask

    task automatic test_bad_checksum();
        frame = '{8'h02, 8'h10, 8'h20, 8'h31};
        run_frame("badsum", 0, 0);
    endtask

    task automatic test_bad_length();
        frame = '{8'h00};
        run_frame("len0", 0, 1);
        frame = '{8'h21};
        run_frame("len33", 0, 1);
        frame = '{8'h20};           // L = MEM_DEPTH is legal
        for (int i = 0; i < 32; i++) frame.push_back(8'($urandom));
        frame.push_back(8'h00);
        for (int i = 1; i <= 32; i++) frame[33] ^= frame[i];
        run_frame("len32", 0, 0);
    endtask

    task automatic test_abort();
        send_byte(8'h04);
        send_byte(8'hA1);
        send_byte(8'hB2);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort ready: got %b want 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        n_vec++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_data, bus.cpu_reset, bus.load_done, bus.load_error}
            !== {1'b0, 5'd1, 8'hB2, S_BUSY}) begin
            n_err++;
            $display("FAIL abort edge: got we=%b addr=%0d data=%h st=%b%b%b want 0 1 b2 100",
                     bus.mem_we, bus.mem_addr, bus.mem_data, bus.cpu_reset, bus.load_done, bus.load_error);
        end
        frame = '{8'h01, 8'h7F, 8'h7F};
        run_frame("after_abort", 0, 0);
    endtask

    task automatic test_reset_mid_data();
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h33;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        n_vec++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_data, bus.cpu_reset, bus.load_done, bus.load_error}
            !== {1'b0, 5'd0, 8'h00, S_BUSY}) begin
            n_err++;
            $display("FAIL rst_mid: got we=%b addr=%0d data=%h st=%b%b%b want 0 0 00 100",
                     bus.mem_we, bus.mem_addr, bus.mem_data, bus.cpu_reset, bus.load_done, bus.load_error);
        end
        // 32-byte frame with In_Valid low every other cycle
        frame = '{8'h20};
        for (int i = 0; i < 32; i++) frame.push_back(8'($urandom));
        frame.push_back(8'h00);
        for (int i = 1; i <= 32; i++) frame[33] ^= frame[i];
        we_count = 0;
        run_frame("gapped32", 1, 1);
        n_vec++;
        if (we_count != 32 || bus.mem_addr !== 5'd31) begin
            n_err++;
            $display("FAIL gapped32 writes: got count=%0d lastaddr=%0d want 32 31", we_count, bus.mem_addr);
        end
    endtask

    task automatic test_done_reframe();
        // Entered from DONE (previous test ends with a good load)
        send_byte(8'h02);
        n_vec++;
        if (bus.cpu_reset !== 1'b1 || bus.load_done !== 1'b0) begin
            n_err++;
            $display("FAIL reframe: got cr=%b dn=%b want 1 0", bus.cpu_reset, bus.load_done);
        end
        send_byte(8'h0F);
        send_byte(8'hF1);
        send_byte(8'hFE);
        n_vec++;
        if ({bus.cpu_reset, bus.load_done, bus.load_error} !== S_DONE) begin
            n_err++;
            $display("FAIL reframe end: got %b%b%b want 010", bus.cpu_reset, bus.load_done, bus.load_error);
        end
    endtask

    task automatic test_random();
        int kind;
        int len;
        logic [7:0] x;
        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(9, 0);
            frame.delete();
            if (kind == 0) begin
                frame.push_back(8'h00);
            end else if (kind == 1) begin
                frame.push_back(8'($urandom_range(255, 33)));
            end else begin
                len = $urandom_range(DEPTH, 1);
                frame.push_back(8'(len));
                x = 8'h00;
                for (int i = 0; i < len; i++) begin
                    frame.push_back(8'($urandom));
                    x ^= frame[i + 1];
                end
                if (kind < 4) x ^= 8'($urandom_range(255, 1));
                frame.push_back(x);
            end
            run_frame("random", 0, 2);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        we_count     = 0;
        rst          = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_abort();
        test_reset_mid_data();
        test_done_reframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
